adar_spi_master_axil: RTL
=========================

// Module: adar_spi_master_axil
// PURPOSE
//  Parametrised AXI4-Lite controlled SPI master for ADAR beamformer chains; successor to the fixed single-device PL SPI block.
//  Drives NUM_CS chip selects, FRAME_W-bit frames and a parametrised SCLK divider; captures MISO into RXDATA.
//  Reports busy/done and flags illegal accesses with SLVERR. Sits between the PS AXI interconnect and the ADAR SPI pins.
// PARAMETERS
//  NUM_CS             4   number of chip selects (1..16)
//  FRAME_W            24  bits per SPI frame (8..32), MSB first
//  CLK_DIV            4   ACLK cycles per SCLK half period (>=2)
//  C_S_AXI_ADDR_WIDTH 4   AXI byte address width; data width fixed at 32
// PORTS
//  ACLK           in  1       clock, all logic rising-edge
//  ARESET         in  1       reset, synchronous, active-high
//  S_AXI_AWADDR   in  AW      write address
//  S_AXI_AWVALID  in  1       write address valid
//  S_AXI_AWREADY  out 1       write address ready
//  S_AXI_WDATA    in  32      write data
//  S_AXI_WSTRB    in  4       byte strobes
//  S_AXI_WVALID   in  1       write data valid
//  S_AXI_WREADY   out 1       write data ready
//  S_AXI_BRESP    out 2       00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out 1       write response valid
//  S_AXI_BREADY   in  1       write response ready
//  S_AXI_ARADDR   in  AW      read address
//  S_AXI_ARVALID  in  1       read address valid
//  S_AXI_ARREADY  out 1       read address ready
//  S_AXI_RDATA    out 32      read data
//  S_AXI_RRESP    out 2       always 00
//  S_AXI_RVALID   out 1       read data valid
//  S_AXI_RREADY   in  1       read data ready
//  spi_sclk       out 1       SPI clock, mode 0 (idle low)
//  spi_mosi       out 1       SPI data out
//  spi_miso       in  1       SPI data in (already synchronous to ACLK domain use)
//  spi_cs_n       out NUM_CS  active-low selects, one-hot-low during frame
//  irq            out 1       level, = STATUS.DONE
// BEHAVIOUR
//  Reset: all READY/VALID 0, BRESP/RRESP 00, RDATA 0, spi_sclk 0, spi_mosi 0, spi_cs_n all 1, irq 0, regs 0, FSM IDLE. Applies mid-frame: frame aborted, cs_n all 1 the cycle after.
//  Regs: 0x0 CTRL [0]START(W1, reads 0) [7:4]CS_SEL; 0x4 STATUS RO [0]BUSY [1]DONE; 0x8 TXDATA [FRAME_W-1:0]; 0xC RXDATA RO. Unused bits read 0.
//  Write: when AWVALID&WVALID&!BVALID, AWREADY=WREADY=1 for exactly one cycle; BVALID next cycle, held until BREADY. WSTRB per byte.
//  SLVERR on: write to CTRL/TXDATA while BUSY (write dropped); START with CS_SEL>=NUM_CS (no frame); write to 0x4/0xC (ignored).
//  Read: ARVALID&!RVALID -> ARREADY one cycle, RVALID next cycle with RDATA stable until RREADY.
//  Simultaneous read and write: independent channels; read of STATUS in the START-accept cycle returns the pre-write value.
//  START (CTRL write, WSTRB[0], legal): BUSY=1 and DONE=0 the cycle after the write handshake; CS_SEL latched.
//  FSM IDLE->SETUP->SHIFT->HOLD->IDLE. SETUP: cs_n[CS_SEL]=0, mosi=TXDATA MSB, CLK_DIV cycles.
//  SHIFT: FRAME_W bits; sclk high CLK_DIV, low CLK_DIV; MISO sampled on rising edge into shift reg; MOSI updates on falling edge.
//  HOLD: sclk 0, CLK_DIV cycles, then cs_n all 1, RXDATA<=shift reg, BUSY=0, DONE=1 same cycle.
//  BUSY duration = CLK_DIV*(2*FRAME_W+2) ACLK cycles. DONE sticky until next legal START.
//  Bit counter wraps only via IDLE; no back-to-back frames without a new START.
// TESTING
//  CLK_DIV=2,FRAME_W=24, miso=mosi: TXDATA=0x0012A5, CTRL=0x11 -> cs_n=4'b1101, 24 sclk pulses, mosi=0x0012A5 MSB first, BUSY 100 cycles, RXDATA=0x0012A5, irq=1.
//  During BUSY write TXDATA=0xFFFFFF -> BRESP=10, TXDATA stays 0x0012A5; STATUS read = 0x1.
//  CTRL=0x51 (CS_SEL=5, NUM_CS=4) -> BRESP=10, cs_n stays 4'b1111, BUSY stays 0.
//  ARESET 1 cycle at bit 10 of frame -> next cycle cs_n=4'b1111, sclk=0, STATUS=0; new START runs full frame.
//  TXDATA write WSTRB=4'b0001 data 0xAABBCC77 over 0x0012A5 -> TXDATA readback 0x001277.
//  BREADY held low 5 cycles -> BVALID held, no new AWREADY until BREADY; RREADY stall keeps RDATA stable.

Source files
------------

// File: rtl/adar_spi_master_axil.sv
// rtl/adar_spi_master_axil.sv - AXI4-Lite controlled SPI master for ADAR beamformer chains
module adar_spi_master_axil #(
    parameter int NUM_CS             = 4,
    parameter int FRAME_W            = 24,
    parameter int CLK_DIV            = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    input  logic                          spi_miso,
    output logic [NUM_CS-1:0]             spi_cs_n,
    output logic                          irq
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0] HI_END   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LO_END   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [4:0]       NUM_CS_L = 5'(NUM_CS);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sclk_q;
    logic [FRAME_W-1:0] tx_shift, rx_shift, txdata_q, rxdata_q;
    logic [NUM_CS-1:0]  cs_n_q;
    logic [3:0]         cs_sel_q;
    logic               done_q, busy;
    logic               awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]         bresp_q;
    logic [31:0]        rdata_q, rd_mux, tx_merged;
    logic               wr_en, rd_en, wr_err, start_ok;
    logic [1:0]         wr_idx, rd_idx;
    logic               unused;

    assign busy   = (state != ST_IDLE);
    assign wr_en  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en  = arready_q & S_AXI_ARVALID;
    assign wr_idx = S_AXI_AWADDR[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];
    assign unused = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR};

    // Decode the accepted write: legal START or error response
    always_comb begin
        start_ok = 1'b0;
        wr_err   = 1'b0;
        if (wr_en) begin
            case (wr_idx)
                2'd0: begin
                    if (busy) begin
                        wr_err = 1'b1;
                    end else if (S_AXI_WSTRB[0] && S_AXI_WDATA[0]) begin
                        if ({1'b0, S_AXI_WDATA[7:4]} >= NUM_CS_L) wr_err = 1'b1;
                        else start_ok = 1'b1;
                    end
                end
                2'd2:    wr_err = busy;
                default: wr_err = 1'b1;
            endcase
        end
    end

    // Byte-strobe merge of new write data over the current TXDATA
    always_comb begin
        tx_merged = '0;
        tx_merged[FRAME_W-1:0] = txdata_q;
        for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) tx_merged[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
    end

    // Register read mux; unused bits read as zero
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            2'd0: rd_mux[7:4] = cs_sel_q;
            2'd1: rd_mux[1:0] = {done_q, busy};
            2'd2: rd_mux[FRAME_W-1:0] = txdata_q;
            default: rd_mux[FRAME_W-1:0] = rxdata_q;
        endcase
    end

    // AXI write/read channel handshakes and config registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            txdata_q  <= '0;
            cs_sel_q  <= '0;
        end else begin
            awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? 2'b10 : 2'b00;
                if (!busy && wr_idx == 2'd2) txdata_q <= tx_merged[FRAME_W-1:0];
                if (!busy && wr_idx == 2'd0 && S_AXI_WSTRB[0]) cs_sel_q <= S_AXI_WDATA[7:4];
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state: one frame per START, always returning through IDLE
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_SETUP;
            ST_SETUP: if (div_cnt == HI_END) state_nx = ST_SHIFT;
            ST_SHIFT: if (div_cnt == LO_END && bit_cnt == LAST_BIT) state_nx = ST_HOLD;
            default:  if (div_cnt == HI_END) state_nx = ST_IDLE;
        endcase
    end

    // SPI datapath: SCLK phases, MOSI shift on fall, MISO capture on rise
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            rxdata_q <= '0;
            cs_n_q   <= '1;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cs_n_q   <= ~(NUM_CS'(1) << S_AXI_WDATA[7:4]);
                        tx_shift <= txdata_q;
                        rx_shift <= '0;
                        done_q   <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (div_cnt == HI_END) begin
                        sclk_q   <= 1'b1;
                        rx_shift <= {rx_shift[FRAME_W-2:0], spi_miso};
                        div_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == HI_END) begin
                        sclk_q   <= 1'b0;
                        tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
                        div_cnt  <= div_cnt + 1'b1;
                    end else if (div_cnt == LO_END) begin
                        div_cnt <= '0;
                        if (bit_cnt != LAST_BIT) begin
                            sclk_q   <= 1'b1;
                            rx_shift <= {rx_shift[FRAME_W-2:0], spi_miso};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    if (div_cnt == HI_END) begin
                        cs_n_q   <= '1;
                        rxdata_q <= rx_shift;
                        done_q   <= 1'b1;
                        div_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = tx_shift[FRAME_W-1];
    assign spi_cs_n      = cs_n_q;
    assign irq           = done_q;

endmodule
